// File: rtl/poly_op_sched.sv
// -----------------------------------------------------------------------------
// poly_op_sched
//   Command scheduler for four polynomial engines sharing one poly RAM port.
//   Opcodes (MULTIPLY, ADD, SUBTRACT, MULTIPLY_PRECOMP) are queued in a
//   2-entry FIFO.  Each command gets a one-cycle start pulse, an enable that
//   is held while it runs, and exclusive use of the RAM write port.  A
//   one-cycle op_done pulse reports which opcode finished.
//
//   Optional feature: define POLY_OP_TIMEOUT_EN to add a RUN watchdog.  An
//   engine that does not finish within TIMEOUT cycles of its start is
//   aborted through a one-cycle ERR state that pulses op_err.  Without the
//   macro there is no watchdog and RUN waits indefinitely.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid, cmd_op   command offer and opcode
//   cmd_ready           FIFO has room
//   busy                FIFO non-empty or scheduler not idle
//   op_done,            completion pulse and opcode of the completed operation
//     op_done_code
//   op_err              watchdog abort pulse (constant 0 without the macro)
//   eng_start, eng_en   one-hot engine start pulse / held enable
//   eng_done, eng_we,   per-engine done pulse and RAM write request
//     eng_addr, eng_dout  (engine n at slice n of the packed buses)
//   ram_we, ram_addr,   shared poly RAM write port
//     ram_din
// -----------------------------------------------------------------------------
module poly_op_sched #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd_op,
    output logic                cmd_ready,
    output logic                busy,
    output logic                op_done,
    output logic [1:0]          op_done_code,
    output logic                op_err,
    output logic [3:0]          eng_start,
    output logic [3:0]          eng_en,
    input  logic [3:0]          eng_done,
    input  logic [3:0]          eng_we,
    input  logic [4*ADDR_W-1:0] eng_addr,
    input  logic [4*DATA_W-1:0] eng_dout,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din
);

    // The watchdog needs at least one RUN cycle before it can abort.
    generate
        if (TIMEOUT < 2) begin : g_timeout_range
            $error("poly_op_sched: TIMEOUT must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3
`ifdef POLY_OP_TIMEOUT_EN
        , ERR = 3'd4
`endif
    } state_t;

    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        op_onehot = 4'b0001 << op;
    endfunction

    state_t     state_r;
    logic [1:0] sel_op_r;
    logic [3:0] eng_start_r;
    logic [3:0] eng_en_r;
    logic       op_done_r;
    logic [1:0] op_done_code_r;

    logic [1:0] fifo_mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;
    logic       push_s;
    logic       pop_s;
    logic [1:0] head_s;

`ifdef POLY_OP_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // The counter holds RUN cycles minus one; aborting when it would step
    // onto TIMEOUT-1 puts op_err exactly TIMEOUT cycles after START.
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 2);
    logic [CNT_W-1:0] wdog_cnt_r;
    logic             op_err_r;
    assign op_err = op_err_r;
`else
    assign op_err = 1'b0;
`endif

    // A full FIFO refuses a push even when the head is popped the same cycle.
    assign cmd_ready    = (count_r < 2'd2);
    assign push_s       = cmd_valid && cmd_ready;
    assign pop_s        = (state_r == IDLE) && (count_r != 2'd0);
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign busy         = (count_r != 2'd0) || (state_r != IDLE);
    assign eng_start    = eng_start_r;
    assign eng_en       = eng_en_r;
    assign op_done      = op_done_r;
    assign op_done_code = op_done_code_r;

    // Command FIFO: two entries addressed by toggling read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_r[0] <= 2'd0;
            fifo_mem_r[1] <= 2'd0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= cmd_op;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Scheduler FSM: dispatches the FIFO head and registers every pulse output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            sel_op_r       <= 2'd0;
            eng_start_r    <= 4'd0;
            eng_en_r       <= 4'd0;
            op_done_r      <= 1'b0;
            op_done_code_r <= 2'd0;
`ifdef POLY_OP_TIMEOUT_EN
            wdog_cnt_r     <= {CNT_W{1'b0}};
            op_err_r       <= 1'b0;
`endif
        end else begin
            eng_start_r    <= 4'd0;
            op_done_r      <= 1'b0;
            op_done_code_r <= 2'd0;
`ifdef POLY_OP_TIMEOUT_EN
            op_err_r       <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        state_r     <= START;
                        sel_op_r    <= head_s;
                        eng_start_r <= op_onehot(head_s);
                        eng_en_r    <= op_onehot(head_s);
                    end else begin
                        state_r  <= IDLE;
                        eng_en_r <= 4'd0;
                    end
                end
                START: begin
                    // eng_done is deliberately not looked at here.
                    state_r <= RUN;
`ifdef POLY_OP_TIMEOUT_EN
                    wdog_cnt_r <= {CNT_W{1'b0}};
`endif
                end
                RUN: begin
                    if (eng_done[sel_op_r]) begin
                        state_r        <= DONE;
                        eng_en_r       <= 4'd0;
                        op_done_r      <= 1'b1;
                        op_done_code_r <= sel_op_r;
`ifdef POLY_OP_TIMEOUT_EN
                    end else if (wdog_cnt_r == WDOG_LAST) begin
                        state_r  <= ERR;
                        eng_en_r <= 4'd0;
                        op_err_r <= 1'b1;
                    end else begin
                        state_r    <= RUN;
                        wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
`else
                    end else begin
                        state_r <= RUN;
`endif
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
`ifdef POLY_OP_TIMEOUT_EN
                ERR: begin
                    state_r <= IDLE;
                end
`endif
                default: begin
                    state_r  <= IDLE;
                    eng_en_r <= 4'd0;
                end
            endcase
        end
    end

    // RAM port mux: only the running engine reaches the RAM, and only in RUN.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = {ADDR_W{1'b0}};
        ram_din  = {DATA_W{1'b0}};
        if (state_r == RUN) begin
            ram_we   = eng_we[sel_op_r];
            ram_addr = eng_addr[int'(sel_op_r)*ADDR_W +: ADDR_W];
            ram_din  = eng_dout[int'(sel_op_r)*DATA_W +: DATA_W];
        end else begin
            ram_we   = 1'b0;
            ram_addr = {ADDR_W{1'b0}};
            ram_din  = {DATA_W{1'b0}};
        end
    end

endmodule
